// File: rtl/pw_pattern_generator.sv
// Transmit-side pattern generator: streams a latched byte pattern, optionally repeated with idle gaps.
// Define PW_PATGEN_FRAME_EN to add the O_capturing run-framing output.
module pw_pattern_generator #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pGAP_BITS      = 8
) (
  input  logic                        fe_clk,
  input  logic                        reset_n,
  input  logic                        I_start,
  input  logic                        I_abort,
  input  logic [pPATTERN_BYTES*8-1:0] I_pattern,
  input  logic [7:0]                  I_pattern_bytes,
  input  logic [pGAP_BITS-1:0]        I_gap,
  input  logic [7:0]                  I_repeat,
  input  logic                        I_ready,
  output logic [7:0]                  O_fe_data,
  output logic                        O_fe_data_valid,
  output logic                        O_busy,
`ifdef PW_PATGEN_FRAME_EN
  output logic                        O_capturing,
`endif
  output logic                        O_done
);

  localparam int                   IW      = (pPATTERN_BYTES > 1) ? $clog2(pPATTERN_BYTES) : 1;
  localparam logic [7:0]           MAX_LEN = 8'(pPATTERN_BYTES);
  localparam logic [pGAP_BITS-1:0] GAP_ONE = pGAP_BITS'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t state, state_nxt;

  logic [pPATTERN_BYTES-1:0][7:0] pat;
  logic [7:0]           len, reps, rep_cnt, idx, start_len;
  logic [pGAP_BITS-1:0] gap, gap_cnt;
  logic                 launch, xfer, end_of_pat, last_byte;

  assign start_len  = (I_pattern_bytes > MAX_LEN) ? MAX_LEN : I_pattern_bytes;
  assign launch     = (state == IDLE) && I_start && !I_abort;
  assign xfer       = (state == SEND) && I_ready;
  assign end_of_pat = (idx == len - 8'd1);
  assign last_byte  = end_of_pat && (rep_cnt == reps);

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = (start_len == 8'd0) ? FIN : SEND;
      SEND: if (xfer) begin
        if (last_byte)        state_nxt = FIN;
        else if (gap != '0)   state_nxt = GAP;
      end
      GAP:  if (gap_cnt <= GAP_ONE) state_nxt = SEND;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition outside IDLE; a same-cycle transfer still lands.
    if (state != IDLE && I_abort) state_nxt = IDLE;
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      pat     <= '0;
      len     <= '0;
      gap     <= '0;
      reps    <= '0;
      idx     <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else if (launch) begin
      pat     <= I_pattern;
      len     <= start_len;
      gap     <= I_gap;
      reps    <= I_repeat;
      idx     <= '0;
      rep_cnt <= '0;
    end else if (xfer && !last_byte) begin
      gap_cnt <= gap;
      if (end_of_pat) begin
        idx     <= '0;
        rep_cnt <= rep_cnt + 8'd1;
      end else begin
        idx     <= idx + 8'd1;
      end
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt - GAP_ONE;
    end
  end

  assign O_fe_data_valid = (state == SEND);
  assign O_fe_data       = O_fe_data_valid ? pat[idx[IW-1:0]] : 8'h00;
  assign O_busy          = (state == SEND) || (state == GAP);
  assign O_done          = (state == FIN);

`ifdef PW_PATGEN_FRAME_EN
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) O_capturing <= 1'b0;
    else          O_capturing <= (state_nxt == SEND) || (state_nxt == GAP);
  end
`endif

endmodule

// File: tb/tb_pw_pattern_generator.sv
// Self-checking bench for pw_pattern_generator: directed scenarios plus randomized runs
// compared against a byte-sequence model built from pattern/length/repeat.
module tb_pw_pattern_generator;

  logic        fe_clk;
  logic        reset_n;
  logic        I_start, I_abort, I_ready;
  logic [63:0] I_pattern;
  logic [7:0]  I_pattern_bytes, I_gap, I_repeat;
  logic [7:0]  O_fe_data;
  logic        O_fe_data_valid, O_busy, O_done;
`ifdef PW_PATGEN_FRAME_EN
  logic        O_capturing;
`endif

  pw_pattern_generator #(.pPATTERN_BYTES(8), .pGAP_BITS(8)) dut (
    .fe_clk(fe_clk), .reset_n(reset_n), .I_start(I_start), .I_abort(I_abort),
    .I_pattern(I_pattern), .I_pattern_bytes(I_pattern_bytes), .I_gap(I_gap),
    .I_repeat(I_repeat), .I_ready(I_ready), .O_fe_data(O_fe_data),
    .O_fe_data_valid(O_fe_data_valid), .O_busy(O_busy),
`ifdef PW_PATGEN_FRAME_EN
    .O_capturing(O_capturing),
`endif
    .O_done(O_done));

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  int n_cmp, n_bad;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int stab_err, gap_err, idle_err, busy_cycles, cap_cycles, done_count, done_cyc;
  int first_valid, last_xfer, timeout;

  // Reference: the delivered stream is the first min(len,8) bytes, repeated rep+1 times.
  task automatic build_exp(input logic [63:0] pat, input logic [7:0] nb, input logic [7:0] rp);
    int len;
    len = (int'(nb) > 8) ? 8 : int'(nb);
    exp_q.delete();
    for (int r = 0; r <= int'(rp); r++)
      for (int k = 0; k < len; k++) exp_q.push_back(pat[8*k +: 8]);
  endtask

  function automatic int seq_diff();
    int d = 0;
    if (got.size() != exp_q.size()) d++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Drives one run from a negedge and records what the stream did.
  task automatic run(input logic [63:0] pat, input logic [7:0] nb, input logic [7:0] gp,
                     input logic [7:0] rp, input int ready_pct, input logic [7:0] stall_byte,
                     input int stall_len, input int abort_after, input bit abort_with_start,
                     input int restart_cyc);
    int cyc, stall_left, pending, abort_cyc, tail;
    bit prev_hold, finished, xfer;
    logic [7:0] prev_data;
    got.delete();
    stab_err = 0; gap_err = 0; idle_err = 0; busy_cycles = 0; cap_cycles = 0;
    done_count = 0; done_cyc = -1; first_valid = -1; last_xfer = 0; timeout = 0;
    stall_left = stall_len; pending = -1; abort_cyc = abort_with_start ? 0 : -1;
    prev_hold = 0; prev_data = 8'h00; finished = 0; tail = 0; cyc = 0;
    I_pattern = pat; I_pattern_bytes = nb; I_gap = gp; I_repeat = rp;
    I_start = 1'b1; I_abort = abort_with_start; I_ready = 1'b1;
    while (!finished) begin
      @(negedge fe_clk);
      cyc++;
      I_start = 1'b0; I_abort = 1'b0;
      I_pattern = {$urandom, $urandom}; I_pattern_bytes = 8'($urandom);
      I_gap = 8'($urandom); I_repeat = 8'($urandom);
      if (abort_cyc >= 0 || (done_cyc >= 0 && cyc > done_cyc))
        if (O_fe_data_valid || O_busy || O_done) idle_err++;
      if (O_fe_data_valid && first_valid < 0) first_valid = cyc;
      if (O_busy) busy_cycles++;
`ifdef PW_PATGEN_FRAME_EN
      if (O_capturing) cap_cycles++;
`endif
      if (O_done) begin done_count++; if (done_cyc < 0) done_cyc = cyc; end
      if (prev_hold && (!O_fe_data_valid || O_fe_data !== prev_data)) stab_err++;
      if (pending >= 0 && O_fe_data_valid) begin
        if (cyc - pending - 1 != int'(gp)) gap_err++;
        pending = -1;
      end
      if (O_fe_data_valid && O_fe_data == stall_byte && stall_left > 0) begin
        I_ready = 1'b0; stall_left--;
      end else I_ready = ($urandom_range(99) < ready_pct);
      xfer = O_fe_data_valid && I_ready;
      if (xfer) begin got.push_back(O_fe_data); last_xfer = cyc; pending = cyc; end
      prev_hold = O_fe_data_valid && !I_ready;
      prev_data = O_fe_data;
      if (abort_after >= 0 && abort_cyc < 0 && got.size() == abort_after) begin
        I_abort = 1'b1; abort_cyc = cyc;
      end
      if (cyc == restart_cyc) I_start = 1'b1;
      if (done_count > 0 || abort_cyc >= 0) tail++;
      if (tail > 3) finished = 1;
      if (cyc > 3000) begin timeout = 1; finished = 1; end
    end
    I_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; I_start = 1'b1; I_abort = 1'b0; I_ready = 1'b1;
    I_pattern = 64'h0807060504030201; I_pattern_bytes = 8'd4; I_gap = 8'd0; I_repeat = 8'd0;
    repeat (3) @(negedge fe_clk);
    n_cmp++; if (O_fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", O_fe_data_valid); end
    n_cmp++; if (O_fe_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", O_fe_data); end
    n_cmp++; if (O_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", O_busy); end
    n_cmp++; if (O_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", O_done); end
`ifdef PW_PATGEN_FRAME_EN
    n_cmp++; if (O_capturing !== 1'b0) begin n_bad++; $display("FAIL reset_capturing: got %b want 0", O_capturing); end
`endif
    I_start = 1'b0;
    reset_n = 1'b1;
    @(negedge fe_clk);
    n_cmp++; if (O_busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: got %b want 0", O_busy); end
  endtask

  task automatic test_basic();
    build_exp(64'h0807060504030201, 8'd4, 8'd0);
    run(64'h0807060504030201, 8'd4, 8'd0, 8'd0, 100, 8'h00, 0, -1, 0, -1);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL basic_seq: got %0d bytes, %0d diffs want 4 bytes 0 diffs", got.size(), seq_diff()); end
    n_cmp++; if (first_valid !== 1) begin n_bad++; $display("FAIL basic_first_valid: got cyc %0d want 1", first_valid); end
    n_cmp++; if (done_cyc !== 5) begin n_bad++; $display("FAIL basic_done_cyc: got %0d want 5", done_cyc); end
    n_cmp++; if (done_count !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
    n_cmp++; if (busy_cycles !== 4) begin n_bad++; $display("FAIL basic_busy: got %0d want 4", busy_cycles); end
    n_cmp++; if (idle_err !== 0) begin n_bad++; $display("FAIL basic_post_done: got %0d want 0", idle_err); end
`ifdef PW_PATGEN_FRAME_EN
    n_cmp++; if (cap_cycles !== 4) begin n_bad++; $display("FAIL basic_capturing: got %0d want 4", cap_cycles); end
`endif
  endtask

  task automatic test_gap_repeat();
    build_exp(64'h0807060504030201, 8'd4, 8'd1);
    run(64'h0807060504030201, 8'd4, 8'd2, 8'd1, 100, 8'h00, 0, -1, 0, -1);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL gaprep_seq: got %0d bytes, %0d diffs want 8 bytes", got.size(), seq_diff()); end
    n_cmp++; if (gap_err !== 0) begin n_bad++; $display("FAIL gaprep_gap: got %0d bad gaps want 0", gap_err); end
    n_cmp++; if (last_xfer !== 22) begin n_bad++; $display("FAIL gaprep_last: got cyc %0d want 22", last_xfer); end
    n_cmp++; if (done_cyc !== 23) begin n_bad++; $display("FAIL gaprep_done_cyc: got %0d want 23", done_cyc); end
    n_cmp++; if (busy_cycles !== 22) begin n_bad++; $display("FAIL gaprep_busy: got %0d want 22", busy_cycles); end
  endtask

  task automatic test_backpressure();
    build_exp(64'h0807060504030201, 8'd4, 8'd0);
    run(64'h0807060504030201, 8'd4, 8'd0, 8'd0, 100, 8'h02, 3, -1, 0, -1);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL bp_seq: got %0d bytes, %0d diffs", got.size(), seq_diff()); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); end
    n_cmp++; if (last_xfer !== 7) begin n_bad++; $display("FAIL bp_last: got cyc %0d want 7", last_xfer); end
    n_cmp++; if (done_cyc !== 8) begin n_bad++; $display("FAIL bp_done_cyc: got %0d want 8", done_cyc); end
  endtask

  task automatic test_clamp();
    build_exp(64'h8877665544332211, 8'd12, 8'd0);
    run(64'h8877665544332211, 8'd12, 8'd0, 8'd0, 100, 8'h00, 0, -1, 0, -1);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL clamp_seq: got %0d bytes want 8", got.size()); end
    n_cmp++; if (done_cyc !== 9) begin n_bad++; $display("FAIL clamp_done_cyc: got %0d want 9", done_cyc); end
    build_exp(64'h8877665544332211, 8'd0, 8'd3);
    run(64'h8877665544332211, 8'd0, 8'd1, 8'd3, 100, 8'h00, 0, -1, 0, -1);
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL zero_bytes: got %0d want 0", got.size()); end
    n_cmp++; if (first_valid !== -1) begin n_bad++; $display("FAIL zero_valid: got cyc %0d want none(-1)", first_valid); end
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want 1", done_cyc); end
    n_cmp++; if (busy_cycles !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", busy_cycles); end
  endtask

  task automatic test_abort();
    build_exp(64'h0807060504030201, 8'd4, 8'd0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    run(64'h0807060504030201, 8'd4, 8'd0, 8'd0, 100, 8'h00, 0, 2, 0, -1);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL abort_seq: got %0d bytes want 2", got.size()); end
    n_cmp++; if (idle_err !== 0) begin n_bad++; $display("FAIL abort_idle: got %0d active cycles want 0", idle_err); end
    n_cmp++; if (done_count !== 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", done_count); end
    run(64'h0807060504030201, 8'd4, 8'd0, 8'd0, 100, 8'h00, 0, -1, 1, -1);
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL abort_start_bytes: got %0d want 0", got.size()); end
    n_cmp++; if (idle_err !== 0) begin n_bad++; $display("FAIL abort_start_idle: got %0d want 0", idle_err); end
  endtask

  task automatic test_restart_ignored();
    build_exp(64'hF0E0D0C0B0A09080, 8'd5, 8'd0);
    run(64'hF0E0D0C0B0A09080, 8'd5, 8'd1, 8'd0, 100, 8'h00, 0, -1, 0, 2);
    n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL restart_seq: got %0d bytes %0d diffs want 5", got.size(), seq_diff()); end
    n_cmp++; if (done_count !== 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", done_count); end
  endtask

  task automatic test_random();
    logic [63:0] pat;
    logic [7:0]  nb, gp, rp;
    int          rdy;
    for (int t = 0; t < 15; t++) begin
      pat = {$urandom, $urandom};
      nb  = 8'($urandom_range(10));
      gp  = 8'($urandom_range(3));
      rp  = 8'($urandom_range(3));
      rdy = 30 + int'($urandom_range(70));
      build_exp(pat, nb, rp);
      run(pat, nb, gp, rp, rdy, 8'h00, 0, -1, 0, -1);
      n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL rnd%0d_timeout: got %0d want 0", t, timeout); end
      n_cmp++; if (seq_diff() !== 0) begin n_bad++; $display("FAIL rnd%0d_seq: got %0d bytes want %0d, %0d diffs", t, got.size(), exp_q.size(), seq_diff()); end
      n_cmp++; if (done_cyc !== last_xfer + 1) begin n_bad++; $display("FAIL rnd%0d_done_cyc: got %0d want %0d", t, done_cyc, last_xfer + 1); end
      n_cmp++; if (done_count !== 1) begin n_bad++; $display("FAIL rnd%0d_done_count: got %0d want 1", t, done_count); end
      n_cmp++; if (stab_err + gap_err + idle_err !== 0) begin n_bad++; $display("FAIL rnd%0d_protocol: got stab=%0d gap=%0d idle=%0d want 0", t, stab_err, gap_err, idle_err); end
      n_cmp++; if (busy_cycles !== last_xfer) begin n_bad++; $display("FAIL rnd%0d_busy: got %0d want %0d", t, busy_cycles, last_xfer); end
    end
  endtask

  task automatic test_mid_reset();
    I_pattern = 64'h0807060504030201; I_pattern_bytes = 8'd8; I_gap = 8'd0; I_repeat = 8'd3;
    I_ready = 1'b1; I_start = 1'b1;
    @(negedge fe_clk); I_start = 1'b0;
    @(negedge fe_clk);
    n_cmp++; if (O_fe_data_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", O_fe_data_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (O_fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", O_fe_data_valid); end
    n_cmp++; if (O_fe_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data: got %h want 00", O_fe_data); end
    n_cmp++; if (O_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", O_busy); end
`ifdef PW_PATGEN_FRAME_EN
    n_cmp++; if (O_capturing !== 1'b0) begin n_bad++; $display("FAIL midrst_capturing: got %b want 0", O_capturing); end
`endif
    @(negedge fe_clk); reset_n = 1'b1;
    @(negedge fe_clk);
    n_cmp++; if (O_fe_data_valid !== 1'b0 || O_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got valid=%b busy=%b want 0 0", O_fe_data_valid, O_busy); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_basic();
    test_gap_repeat();
    test_backpressure();
    test_clamp();
    test_abort();
    test_restart_ignored();
    test_random();
    test_mid_reset();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
